// File: rtl/hdmi_controller_tmds_period_sequencer.sv
// TMDS period sequencer: builds the three TMDS channel words and the clock
// lane word each pixel clock. Video is delayed 10 cycles so the live DE can
// look ahead and schedule the preamble and leading guard band.
module hdmi_controller_tmds_period_sequencer #(
    parameter int unsigned HDMI_MODE = 1,
    parameter int unsigned MIN_CTRL  = 12
) (
    input  logic              pixel_clk,
    input  logic              rest,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              de_in,
    input  logic [2:0][9:0]   video_in,
    output logic [3:0][9:0]   data,
    output logic              video_active,
    output logic              preamble_skip
);

    localparam logic [9:0] TOK_00     = 10'b1101010100;
    localparam logic [9:0] TOK_01     = 10'b0010101011;
    localparam logic [9:0] TOK_10     = 10'b0101010100;
    localparam logic [9:0] TOK_11     = 10'b1010101011;
    localparam logic [9:0] GUARD_CH02 = 10'b1011001100;
    localparam logic [9:0] GUARD_CH1  = 10'b0100110011;
    localparam logic [9:0] CLK_WORD   = 10'b0000011111;
    localparam logic       HDMI_EN    = (HDMI_MODE != 0);
    localparam logic [3:0] MIN_CTRL_C = 4'(MIN_CTRL);

    typedef enum logic [1:0] {
        S_CTRL,
        S_PRE,
        S_GUARD,
        S_VIDEO
    } state_t;

    function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
        logic [9:0] tok;
        case ({c1, c0})
            2'b00:   tok = TOK_00;
            2'b01:   tok = TOK_01;
            2'b10:   tok = TOK_10;
            default: tok = TOK_11;
        endcase
        return tok;
    endfunction

    // Delay line: index 0 is the youngest stage, index 9 the oldest.
    logic [9:0]           dly_h_q, dly_h_d;
    logic [9:0]           dly_v_q, dly_v_d;
    logic [9:0]           dly_de_q, dly_de_d;
    logic [9:0][2:0][9:0] dly_vid_q, dly_vid_d;

    logic [3:0]           ctrl_cnt_q, ctrl_cnt_d;
    state_t               state_q, state_d;
    logic [2:0]           phase_q, phase_d;
    logic [2:0][9:0]      lane_q, lane_d;
    logic                 video_active_q, video_active_d;
    logic                 skip_q, skip_d;

    logic                 de_rise;
    logic                 rise_legal;

    // Stage 0 of the DE delay line doubles as the previous-cycle DE for rise detection.
    assign de_rise    = de_in & ~dly_de_q[0];
    assign rise_legal = HDMI_EN & (ctrl_cnt_q >= MIN_CTRL_C);

    // Shift the sync/DE/video stream and track consecutive DE-low cycles.
    always_comb begin
        dly_h_d   = {dly_h_q[8:0], hsync_in};
        dly_v_d   = {dly_v_q[8:0], vsync_in};
        dly_de_d  = {dly_de_q[8:0], de_in};
        dly_vid_d = {dly_vid_q[8:0], video_in};
        if (de_in) begin
            ctrl_cnt_d = '0;
        end else if (ctrl_cnt_q == 4'd15) begin
            ctrl_cnt_d = ctrl_cnt_q;
        end else begin
            ctrl_cnt_d = ctrl_cnt_q + 4'd1;
        end
    end

    // Period FSM: state_q always describes the words currently on data.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        skip_d  = 1'b0;
        case (state_q)
            S_CTRL: begin
                if (de_rise) begin
                    if (rise_legal) begin
                        state_d = S_PRE;
                        phase_d = '0;
                    end else begin
                        skip_d = HDMI_EN;
                    end
                end
            end
            S_PRE: begin
                skip_d = de_rise;
                if (phase_q == 3'd7) begin
                    state_d = S_GUARD;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            S_GUARD: begin
                skip_d = de_rise;
                if (phase_q == 3'd1) begin
                    state_d = S_VIDEO;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            S_VIDEO: begin
                skip_d = de_rise;
                if (!dly_de_q[9]) begin
                    state_d = S_CTRL;
                end
            end
            default: begin
                state_d = S_CTRL;
                phase_d = '0;
            end
        endcase
    end

    // Lane word selection is driven from the next state so the registered
    // words and the registered state describe the same output cycle.
    always_comb begin
        video_active_d = dly_de_q[9];
        lane_d[0]      = ctrl_token(dly_v_q[9], dly_h_q[9]);
        lane_d[1]      = TOK_00;
        lane_d[2]      = TOK_00;
        case (state_d)
            S_PRE: begin
                lane_d[1] = TOK_01;
            end
            S_GUARD: begin
                lane_d[0] = GUARD_CH02;
                lane_d[1] = GUARD_CH1;
                lane_d[2] = GUARD_CH02;
            end
            default: begin
                if (dly_de_q[9]) begin
                    lane_d = dly_vid_q[9];
                end
            end
        endcase
    end

    // State, delay line and output registers with synchronous reset.
    always_ff @(posedge pixel_clk) begin
        if (rest) begin
            dly_h_q        <= '0;
            dly_v_q        <= '0;
            dly_de_q       <= '0;
            dly_vid_q      <= '0;
            ctrl_cnt_q     <= '0;
            state_q        <= S_CTRL;
            phase_q        <= '0;
            lane_q         <= {TOK_00, TOK_00, TOK_00};
            video_active_q <= 1'b0;
            skip_q         <= 1'b0;
        end else begin
            dly_h_q        <= dly_h_d;
            dly_v_q        <= dly_v_d;
            dly_de_q       <= dly_de_d;
            dly_vid_q      <= dly_vid_d;
            ctrl_cnt_q     <= ctrl_cnt_d;
            state_q        <= state_d;
            phase_q        <= phase_d;
            lane_q         <= lane_d;
            video_active_q <= video_active_d;
            skip_q         <= skip_d;
        end
    end

    assign data          = {CLK_WORD, lane_q};
    assign video_active  = video_active_q;
    assign preamble_skip = skip_q;

endmodule

// File: tb/tb_hdmi_controller_tmds_period_sequencer.sv
// Scoreboard bench for the TMDS period sequencer: an HDMI-mode and a DVI-mode
// instance share the same stimulus; a schedule-based reference model predicts
// every output cycle and a monitor compares.
module tb_hdmi_controller_tmds_period_sequencer;

    localparam int MAXC     = 4096;
    localparam int MIN_CTRL = 12;
    localparam logic [9:0] CLK_WORD = 10'b0000011111;

    typedef struct packed {
        logic [3:0][9:0] data;
        logic            va;
        logic            skip;
    } exp_t;

    logic            pixel_clk = 1'b0;
    logic            rest      = 1'b1;
    logic            hsync_in  = 1'b0;
    logic            vsync_in  = 1'b0;
    logic            de_in     = 1'b0;
    logic [2:0][9:0] video_in  = '0;

    logic [3:0][9:0] data_h, data_v;
    logic            va_h, va_v, skip_h, skip_v;

    int checks = 0;
    int errors = 0;

    // Token lookup indexed by {c1,c0}.
    logic [9:0] tok_tab [4] = '{10'b1101010100, 10'b0010101011,
                                10'b0101010100, 10'b1010101011};

    // Reference model state.
    bit              hh   [MAXC];
    bit              hv   [MAXC];
    bit              hde  [MAXC];
    logic [2:0][9:0] hvid [MAXC];
    bit              pre_mark  [2][MAXC];
    bit              grd_mark  [2][MAXC];
    bit              skip_mark [2][MAXC];
    bit              line_open [2];
    int              busy_end  [2] = '{-1, -1};
    int              cnt     = 0;
    bit              prev_de = 1'b0;
    int              cyc     = 0;

    exp_t q_h[$];
    exp_t q_v[$];

    hdmi_controller_tmds_period_sequencer #(.HDMI_MODE(1), .MIN_CTRL(MIN_CTRL)) dut_hdmi (
        .pixel_clk    (pixel_clk),
        .rest         (rest),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .de_in        (de_in),
        .video_in     (video_in),
        .data         (data_h),
        .video_active (va_h),
        .preamble_skip(skip_h)
    );

    hdmi_controller_tmds_period_sequencer #(.HDMI_MODE(0), .MIN_CTRL(MIN_CTRL)) dut_dvi (
        .pixel_clk    (pixel_clk),
        .rest         (rest),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .de_in        (de_in),
        .video_in     (video_in),
        .data         (data_v),
        .video_active (va_v),
        .preamble_skip(skip_v)
    );

    always #5 pixel_clk = ~pixel_clk;

    // Advance the model by one input cycle and queue the output due next cycle.
    task automatic model_step(input bit r, input bit h, input bit v, input bit de,
                              input logic [2:0][9:0] vid);
        int   c;
        int   t;
        int   src;
        bit   rise;
        exp_t e;
        c = cyc;
        t = c + 1;
        hh[c] = h; hv[c] = v; hde[c] = de; hvid[c] = vid;
        if (r) begin
            for (int i = c - 10; i <= c; i++) begin
                if (i >= 0) begin
                    hh[i] = 1'b0; hv[i] = 1'b0; hde[i] = 1'b0; hvid[i] = '0;
                end
            end
            for (int m = 0; m < 2; m++) begin
                line_open[m] = 1'b0;
                busy_end[m]  = c;
                for (int i = c + 1; i <= c + 11; i++) begin
                    pre_mark[m][i] = 1'b0; grd_mark[m][i] = 1'b0; skip_mark[m][i] = 1'b0;
                end
            end
            cnt = 0;
            prev_de = 1'b0;
        end else begin
            rise = de && !prev_de;
            if (line_open[1] && !de) begin
                line_open[1] = 1'b0;
                busy_end[1]  = c + 10;
            end
            if (rise) begin
                if (!line_open[1] && c > busy_end[1] && cnt >= MIN_CTRL) begin
                    line_open[1] = 1'b1;
                    for (int i = c + 1; i <= c + 8; i++) pre_mark[1][i] = 1'b1;
                    grd_mark[1][c + 9]  = 1'b1;
                    grd_mark[1][c + 10] = 1'b1;
                end else begin
                    skip_mark[1][t] = 1'b1;
                end
            end
            cnt = de ? 0 : ((cnt < 15) ? cnt + 1 : 15);
            prev_de = de;
        end
        src = c - 10;
        for (int m = 0; m < 2; m++) begin
            bit              sh, sv, sde;
            logic [2:0][9:0] svid;
            sh = 1'b0; sv = 1'b0; sde = 1'b0; svid = '0;
            if (src >= 0) begin
                sh = hh[src]; sv = hv[src]; sde = hde[src]; svid = hvid[src];
            end
            e.data[3] = CLK_WORD;
            e.data[0] = tok_tab[{sv, sh}];
            e.data[1] = tok_tab[0];
            e.data[2] = tok_tab[0];
            if (pre_mark[m][t]) begin
                e.data[1] = tok_tab[1];
            end else if (grd_mark[m][t]) begin
                e.data[0] = 10'h2CC;
                e.data[1] = 10'h133;
                e.data[2] = 10'h2CC;
            end else if (sde) begin
                e.data[2:0] = svid;
            end
            e.va   = sde;
            e.skip = skip_mark[m][t];
            if (m == 1) q_h.push_back(e);
            else        q_v.push_back(e);
        end
        cyc++;
    endtask

    task automatic drive(input bit r, input bit h, input bit v, input bit de,
                         input logic [2:0][9:0] vid);
        @(negedge pixel_clk);
        rest = r; hsync_in = h; vsync_in = v; de_in = de; video_in = vid;
        model_step(r, h, v, de, vid);
    endtask

    task automatic drive_rand(input bit r, input bit de);
        logic [2:0][9:0] vid;
        vid = {10'($urandom), 10'($urandom), 10'($urandom)};
        drive(r, 1'($urandom), 1'($urandom), de, vid);
    endtask

    task automatic compare(input string name, input int cy, input exp_t e,
                           input logic [3:0][9:0] d, input logic va, input logic sk);
        checks++;
        if (d !== e.data || va !== e.va || sk !== e.skip) begin
            errors++;
            $display("FAIL %s cyc=%0d got data=%h va=%b skip=%b expected data=%h va=%b skip=%b",
                     name, cy, d, va, sk, e.data, e.va, e.skip);
        end
    endtask

    // Monitor: every cycle is an output cycle; pop and compare after the edge.
    initial begin
        int   ocyc;
        exp_t e;
        ocyc = 0;
        forever begin
            @(posedge pixel_clk);
            #2;
            if (q_h.size() > 0) begin
                ocyc++;
                e = q_h.pop_front();
                compare("hdmi", ocyc, e, data_h, va_h, skip_h);
            end
            if (q_v.size() > 0) begin
                e = q_v.pop_front();
                compare("dvi", ocyc, e, data_v, va_v, skip_v);
            end
        end
    end

    initial begin
        logic [2:0][9:0] line_vid;
        line_vid = {10'h2AA, 10'h155, 10'h3FF};

        // Reset held three cycles.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        // Sync token patterns.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
        // Legal HDMI line.
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++)  drive(1'b0, 1'b0, 1'b0, 1'b1, line_vid);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        // Short blanking before a rise.
        for (int i = 0; i < 3; i++)  drive_rand(1'b0, 1'b1);
        for (int i = 0; i < 8; i++)  drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++)  drive_rand(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        // Reset during preamble, then an immediate DE rise.
        for (int i = 0; i < 4; i++)  drive_rand(1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 2; i++)  drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++)  drive_rand(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        // Randomized blanking/active runs with occasional resets.
        for (int s = 0; s < 45; s++) begin
            int lo;
            int hi;
            lo = int'($urandom_range(1, 20));
            hi = int'($urandom_range(1, 14));
            for (int i = 0; i < lo; i++) drive_rand(($urandom_range(0, 99) == 0), 1'b0);
            for (int i = 0; i < hi; i++) drive_rand(($urandom_range(0, 99) == 0), 1'b1);
        end
        for (int i = 0; i < 15; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0);

        @(posedge pixel_clk);
        #5;
        checks++;
        if (q_h.size() != 0 || q_v.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d/%0d expected pending=0/0", q_h.size(), q_v.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
